// File: rtl/bcp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_pkg
//  Description : Shared types for the Boolean-constraint-propagation engine.
//  Revision    : 1.0
// ============================================================================
package bcp_pkg;

  localparam int DEF_VAR_NUM = 4;
  localparam int DEF_IDX_W   = $clog2(DEF_VAR_NUM);

  // Literal layout for the default variable count, MSB first: {en, pol, idx}
  typedef struct packed {
    logic                 en;
    logic                 pol;
    logic [DEF_IDX_W-1:0] idx;
  } lit_t;

  typedef enum logic [1:0] {L_TRUE, L_FALSE, L_FREE} lit_status_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} bcp_state_e;

  typedef enum logic [1:0] {C_SAT, C_UNIT, C_CONFLICT, C_OPEN} clause_res_e;

  function automatic lit_status_e lit_status(input logic pol, input logic val, input logic is_free);
    if (is_free) return L_FREE;
    return (val == pol) ? L_TRUE : L_FALSE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcp_clause_eval.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_clause_eval
//  Description : Classifies one clause against the current partial assignment.
//  Revision    : 1.0
// ============================================================================
module bcp_clause_eval
  import bcp_pkg::*;
#(
  parameter int VAR_NUM     = 4,
  parameter int VAR_NUM_LOG = $clog2(VAR_NUM),
  parameter int LITS        = 3,
  parameter int LIT_W       = VAR_NUM_LOG + 2
) (
  input  logic [LITS*LIT_W-1:0] i_clause,
  input  logic [VAR_NUM-1:0]    i_asg,
  input  logic [VAR_NUM-1:0]    i_free,
  output clause_res_e           o_result,
  output logic [VAR_NUM_LOG-1:0] o_unit_idx,
  output logic                  o_unit_val
);

  logic [LITS-1:0]        w_en;
  logic [LITS-1:0]        w_pol;
  logic [VAR_NUM_LOG-1:0] w_idx  [LITS];
  lit_status_e            w_stat [LITS];
  logic                   w_any_true;
  logic [1:0]             w_n_free;

  for (genvar k = 0; k < LITS; k++) begin : g_slot
    assign w_en[k]   = i_clause[k*LIT_W + LIT_W - 1];
    assign w_pol[k]  = i_clause[k*LIT_W + LIT_W - 2];
    assign w_idx[k]  = i_clause[k*LIT_W +: VAR_NUM_LOG];
    assign w_stat[k] = lit_status(w_pol[k], i_asg[w_idx[k]], i_free[w_idx[k]]);
  end

  // Free count saturates at 2: only "none" vs "exactly one" matters.
  always_comb begin
    w_any_true = 1'b0;
    w_n_free   = 2'd0;
    o_unit_idx = '0;
    o_unit_val = 1'b0;
    for (int k = 0; k < LITS; k++) begin
      if (w_en[k]) begin
        if (w_stat[k] == L_TRUE) begin
          w_any_true = 1'b1;
        end else if (w_stat[k] == L_FREE) begin
          if (w_n_free != 2'd2) w_n_free = w_n_free + 2'd1;
          o_unit_idx = w_idx[k];
          o_unit_val = w_pol[k];
        end
      end
    end
    if (w_any_true)           o_result = C_SAT;
    else if (w_n_free == 2'd0) o_result = C_CONFLICT;
    else if (w_n_free == 2'd1) o_result = C_UNIT;
    else                      o_result = C_OPEN;
  end

endmodule
`default_nettype wire

// File: rtl/bcp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bcp_engine
//  Description : Clause store plus multi-pass unit-propagation sequencer.
//  Revision    : 1.0
// ============================================================================
module bcp_engine
  import bcp_pkg::*;
#(
  parameter int VAR_NUM     = 4,
  parameter int VAR_NUM_LOG = $clog2(VAR_NUM),
  parameter int CLAUSE_NUM  = 12,
  parameter int LITS        = 3,
  parameter int LIT_W       = VAR_NUM_LOG + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_request,
  input  logic                          init_valid,
  input  logic [LITS*LIT_W-1:0]         init_data,
  input  logic                          init_last,
  output logic                          init_ready,
  input  logic                          bcp_request,
  input  logic [VAR_NUM-1:0]            assignment_in,
  input  logic [VAR_NUM-1:0]            free_in,
  output logic                          busy,
  output logic                          bcp_done,
  output logic                          conflict,
  output logic [$clog2(CLAUSE_NUM)-1:0] conflict_idx,
  output logic [VAR_NUM-1:0]            assignment_out,
  output logic [VAR_NUM-1:0]            free_out,
  output logic [VAR_NUM_LOG:0]          imply_cnt
);

  localparam int CW    = LITS * LIT_W;
  localparam int PTR_W = $clog2(CLAUSE_NUM);
  localparam int CNT_W = $clog2(CLAUSE_NUM + 1);
  localparam int IMP_W = VAR_NUM_LOG + 1;

  bcp_state_e          state_q, state_d;
  logic [CNT_W-1:0]    clause_cnt_q, clause_cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                changed_q, changed_d;
  logic [VAR_NUM-1:0]  asg_q, asg_d, free_q, free_d;
  logic [IMP_W-1:0]    imply_cnt_q, imply_cnt_d;
  logic                conflict_q, conflict_d;
  logic [PTR_W-1:0]    conflict_idx_q, conflict_idx_d;
  logic                bcp_done_q, bcp_done_d;
  logic [CW-1:0]       mem_q [CLAUSE_NUM];

  clause_res_e            w_res;
  logic [VAR_NUM_LOG-1:0] w_unit_idx;
  logic                   w_unit_val;
  logic                   w_wr_en;
  logic                   w_last_clause;
  logic                   w_changed;

  bcp_clause_eval #(
    .VAR_NUM     (VAR_NUM),
    .VAR_NUM_LOG (VAR_NUM_LOG),
    .LITS        (LITS),
    .LIT_W       (LIT_W)
  ) u_eval (
    .i_clause   (mem_q[ptr_q]),
    .i_asg      (asg_q),
    .i_free     (free_q),
    .o_result   (w_res),
    .o_unit_idx (w_unit_idx),
    .o_unit_val (w_unit_val)
  );

  assign init_ready     = (state_q == S_LOAD) && (clause_cnt_q < CNT_W'(CLAUSE_NUM));
  assign busy           = (state_q == S_LOAD) || (state_q == S_EVAL);
  assign bcp_done       = bcp_done_q;
  assign conflict       = conflict_q;
  assign conflict_idx   = conflict_idx_q;
  assign assignment_out = asg_q;
  assign free_out       = free_q;
  assign imply_cnt      = imply_cnt_q;

  assign w_wr_en       = init_valid && init_ready;
  assign w_last_clause = (CNT_W'(ptr_q) + CNT_W'(1)) == clause_cnt_q;
  assign w_changed     = changed_q || (w_res == C_UNIT);

  always_comb begin
    state_d        = state_q;
    clause_cnt_d   = clause_cnt_q;
    ptr_d          = ptr_q;
    changed_d      = changed_q;
    asg_d          = asg_q;
    free_d         = free_q;
    imply_cnt_d    = imply_cnt_q;
    conflict_d     = conflict_q;
    conflict_idx_d = conflict_idx_q;
    bcp_done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_request) begin
          state_d      = S_LOAD;
          clause_cnt_d = '0;
        end else if (bcp_request) begin
          asg_d          = assignment_in;
          free_d         = free_in;
          ptr_d          = '0;
          changed_d      = 1'b0;
          imply_cnt_d    = '0;
          conflict_d     = 1'b0;
          conflict_idx_d = '0;
          // An empty clause set has nothing to scan.
          state_d        = (clause_cnt_q == '0) ? S_DONE : S_EVAL;
        end
      end
      S_LOAD: begin
        if (w_wr_en) clause_cnt_d = clause_cnt_q + CNT_W'(1);
        if (init_valid && init_last) state_d = S_IDLE;
      end
      S_EVAL: begin
        if (w_res == C_CONFLICT) begin
          conflict_d     = 1'b1;
          conflict_idx_d = ptr_q;
          state_d        = S_DONE;
        end else begin
          if (w_res == C_UNIT) begin
            asg_d[w_unit_idx]  = w_unit_val;
            free_d[w_unit_idx] = 1'b0;
            imply_cnt_d        = imply_cnt_q + IMP_W'(1);
          end
          changed_d = w_changed;
          if (!w_last_clause) begin
            ptr_d = ptr_q + PTR_W'(1);
          end else if (w_changed) begin
            ptr_d     = '0;
            changed_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        bcp_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      clause_cnt_q   <= '0;
      ptr_q          <= '0;
      changed_q      <= 1'b0;
      asg_q          <= '0;
      free_q         <= '0;
      imply_cnt_q    <= '0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      bcp_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clause_cnt_q   <= clause_cnt_d;
      ptr_q          <= ptr_d;
      changed_q      <= changed_d;
      asg_q          <= asg_d;
      free_q         <= free_d;
      imply_cnt_q    <= imply_cnt_d;
      conflict_q     <= conflict_d;
      conflict_idx_q <= conflict_idx_d;
      bcp_done_q     <= bcp_done_d;
    end
  end

  // Contents are only meaningful below clause_cnt_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[PTR_W'(clause_cnt_q)] <= init_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_bcp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcp_engine
//  Description : Randomised scoreboard bench for bcp_engine with a
//                clause-list propagation reference model.
//  Revision    : 1.0
// ============================================================================
module tb_bcp_engine;
  import bcp_pkg::*;

  localparam int NCL = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_request = 1'b0;
  logic        init_valid = 1'b0;
  logic [11:0] init_data = '0;
  logic        init_last = 1'b0;
  logic        init_ready;
  logic        bcp_request = 1'b0;
  logic [3:0]  assignment_in = '0;
  logic [3:0]  free_in = '0;
  logic        busy, bcp_done, conflict;
  logic [3:0]  conflict_idx;
  logic [3:0]  assignment_out, free_out;
  logic [2:0]  imply_cnt;

  bcp_engine dut (
    .clk(clk), .rst(rst),
    .init_request(init_request), .init_valid(init_valid), .init_data(init_data),
    .init_last(init_last), .init_ready(init_ready),
    .bcp_request(bcp_request), .assignment_in(assignment_in), .free_in(free_in),
    .busy(busy), .bcp_done(bcp_done), .conflict(conflict), .conflict_idx(conflict_idx),
    .assignment_out(assignment_out), .free_out(free_out), .imply_cnt(imply_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] asg;
    logic [3:0] fr;
    bit         conf;
    int         cidx;
    int         imp;
    int         evals;
    int         due;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] mq[$];
  logic [11:0] stage[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t mon_e;
  exp_t last_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] mk_lit(input bit pos, input int idx);
    logic [1:0] i2;
    i2 = idx[1:0];
    return {1'b1, pos, i2};
  endfunction

  function automatic logic [11:0] mk_cl(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {c, b, a};
  endfunction

  // Reference: sweep the clause list in order, applying units immediately,
  // until a sweep makes no implication or some clause has every literal false.
  function automatic exp_t run_model(input logic [3:0] a, input logic [3:0] f);
    exp_t e;
    bit   changed;
    int   nt, nf, ui;
    bit   uv;
    lit_t l;
    e.asg = a; e.fr = f; e.conf = 0; e.cidx = 0; e.imp = 0; e.evals = 0; e.due = 0;
    if (mq.size() == 0) return e;
    do begin
      changed = 0;
      for (int c = 0; c < mq.size(); c++) begin
        nt = 0; nf = 0; ui = 0; uv = 0;
        e.evals++;
        for (int k = 0; k < 3; k++) begin
          l = lit_t'(mq[c][k*4 +: 4]);
          if (l.en) begin
            if (e.fr[l.idx]) begin
              nf++; ui = int'(l.idx); uv = l.pol;
            end else if (e.asg[l.idx] == l.pol) begin
              nt++;
            end
          end
        end
        if (nt == 0 && nf == 0) begin
          e.conf = 1; e.cidx = c;
          return e;
        end
        if (nt == 0 && nf == 1) begin
          e.asg[ui] = uv; e.fr[ui] = 1'b0; e.imp++; changed = 1;
        end
      end
    end while (changed);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bcp_done === 1'b1) begin
      done_cnt++;
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got bcp_done=1 expected no pending run (t=%0t)", $time);
      end else begin
        mon_e = expq.pop_front();
        chk("done_cycle", cyc, mon_e.due);
        chk("assignment_out", {28'b0, assignment_out}, {28'b0, mon_e.asg});
        chk("free_out", {28'b0, free_out}, {28'b0, mon_e.fr});
        chk("conflict", {31'b0, conflict}, {31'b0, mon_e.conf});
        chk("imply_cnt", {29'b0, imply_cnt}, mon_e.imp);
        if (mon_e.conf) chk("conflict_idx", {28'b0, conflict_idx}, mon_e.cidx);
      end
    end
  end

  task automatic load_stage();
    @(negedge clk); init_request = 1'b1;
    @(negedge clk); init_request = 1'b0;
    mq.delete();
    for (int i = 0; i < stage.size(); i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      chk("init_ready", {31'b0, init_ready}, (mq.size() < NCL) ? 1 : 0);
      init_valid = 1'b1;
      init_data  = stage[i];
      init_last  = (i == stage.size() - 1);
      @(negedge clk);
      if (mq.size() < NCL) mq.push_back(stage[i]);
      init_valid = 1'b0;
      init_last  = 1'b0;
    end
    chk("busy_after_load", {31'b0, busy}, 0);
  endtask

  task automatic run_bcp(input logic [3:0] a, input logic [3:0] f, input bit poke);
    exp_t e;
    int   start;
    e = run_model(a, f);
    e.due = cyc + 1 + e.evals + 1;
    expq.push_back(e);
    last_e = e;
    start = done_cnt;
    assignment_in = a; free_in = f; bcp_request = 1'b1;
    @(negedge clk); bcp_request = 1'b0;
    if (poke && e.evals >= 3) begin
      assignment_in = ~a; free_in = ~f; bcp_request = 1'b1;
      @(negedge clk); bcp_request = 1'b0;
    end
    for (int t = 0; t < 400 && done_cnt == start; t++) @(negedge clk);
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no bcp_done expected one within 400 cycles");
      expq.delete();
    end
    repeat (2) @(negedge clk);
    chk("held_assignment", {28'b0, assignment_out}, {28'b0, e.asg});
    chk("held_conflict", {31'b0, conflict}, {31'b0, e.conf});
    chk("done_is_pulse", {31'b0, bcp_done}, 0);
  endtask

  task automatic rand_stage();
    logic [11:0] cl;
    int n;
    stage.delete();
    n = $urandom_range(1, 13);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        cl[k*4 +: 4] = {($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7))};
      end
      stage.push_back(cl);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_bcp_done"}, {31'b0, bcp_done}, 0);
    chk({tag, "_conflict"}, {31'b0, conflict}, 0);
    chk({tag, "_init_ready"}, {31'b0, init_ready}, 0);
    chk({tag, "_assignment_out"}, {28'b0, assignment_out}, 0);
    chk({tag, "_free_out"}, {28'b0, free_out}, 0);
    chk({tag, "_imply_cnt"}, {29'b0, imply_cnt}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Empty clause set: finishes one cycle after the request, outputs mirror inputs.
    run_bcp(4'b1001, 4'b0110, 1'b0);

    stage.delete();
    stage.push_back(mk_cl(mk_lit(1, 0), mk_lit(1, 1), 4'b0));
    stage.push_back(mk_cl(mk_lit(0, 1), mk_lit(1, 2), 4'b0));
    load_stage();
    run_bcp(4'b1010, 4'b1110, 1'b0);
    chk("t1_free_out", {28'b0, free_out}, 32'h8);
    chk("t1_imply_cnt", {29'b0, imply_cnt}, 2);
    chk("t1_x1x2_set", {30'b0, assignment_out[2:1]}, 3);

    stage.delete();
    stage.push_back(mk_cl(mk_lit(0, 0), mk_lit(1, 1), 4'b0));
    stage.push_back(mk_cl(mk_lit(0, 1), mk_lit(0, 0), 4'b0));
    load_stage();
    run_bcp(4'b0001, 4'b1110, 1'b0);
    chk("t2_conflict", {31'b0, conflict}, 1);
    chk("t2_conflict_idx", {28'b0, conflict_idx}, 1);

    // Chain listed in reverse, plus an ignored request mid-run.
    stage.delete();
    stage.push_back(mk_cl(mk_lit(0, 2), mk_lit(1, 3), 4'b0));
    stage.push_back(mk_cl(mk_lit(0, 1), mk_lit(1, 2), 4'b0));
    stage.push_back(mk_cl(mk_lit(0, 0), mk_lit(1, 1), 4'b0));
    load_stage();
    run_bcp(4'b0001, 4'b1110, 1'b1);
    chk("t3_free_out", {28'b0, free_out}, 0);
    chk("t3_imply_cnt", {29'b0, imply_cnt}, 3);
    chk("t3_latency", last_e.evals + 1, 13);

    // Thirteen beats into a twelve-entry store.
    stage.delete();
    for (int i = 0; i < 13; i++) stage.push_back(mk_cl(mk_lit(1, i % 4), mk_lit(1, (i + 1) % 4), mk_lit(1, (i + 2) % 4)));
    load_stage();
    chk("stored_clauses", mq.size(), NCL);
    run_bcp(4'b0000, 4'b1111, 1'b1);

    for (int r = 0; r < 30; r++) begin
      rand_stage();
      load_stage();
      for (int j = 0; j < 3; j++) run_bcp(4'($urandom), 4'($urandom), j == 0);
    end

    // Asynchronous reset in the middle of a long scan.
    stage.delete();
    for (int i = 0; i < 12; i++) stage.push_back(mk_cl(mk_lit(1, 0), mk_lit(1, 1), mk_lit(1, 2)));
    load_stage();
    assignment_in = 4'b0000; free_in = 4'b1111; bcp_request = 1'b1;
    @(negedge clk); bcp_request = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_eval", {31'b0, busy}, 1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk); rst = 1'b1;
    mq.delete();
    @(negedge clk);
    run_bcp(4'b0110, 4'b1001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
